// File: rtl/adc_if_pkg.sv
// Shared definitions for the ADC LVDS DDR emulator (transmit side).
// Widths, source encodings, idle code, PRBS-7 taps/seeds and FSM states.
package adc_if_pkg;

    localparam int DW = 6;
    localparam int CNT_W = 16;

    localparam logic [DW-1:0] IDLE_CODE = 6'h00;

    localparam logic [6:0] SEED1 = 7'h7F;
    localparam logic [6:0] SEED2 = 7'h3C;

    // x^7 + x^6 + 1, taps on bits 6 and 5
    localparam int PRBS_TAP_A = 6;
    localparam int PRBS_TAP_B = 5;

    typedef enum logic [1:0] {
        MODE_STREAM = 2'd0,
        MODE_RAMP   = 2'd1,
        MODE_PRBS   = 2'd2,
        MODE_FIXED  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [6:0] prbs7_next(input logic [6:0] v);
        return {v[5:0], v[PRBS_TAP_A] ^ v[PRBS_TAP_B]};
    endfunction

endpackage

// File: rtl/adc_pattern_gen.sv
// Test-pattern sources: ramp counter, two PRBS-7 generators, fixed values.
// Output reflects the current state; advance steps all sources together.
module adc_pattern_gen
    import adc_if_pkg::*;
#(
    parameter int         W     = DW,
    parameter logic [W-1:0] IDLE = IDLE_CODE,
    parameter logic [6:0] S1    = SEED1,
    parameter logic [6:0] S2    = SEED2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    input  logic         reload,
    input  logic [1:0]   mode,
    input  logic [W-1:0] fixed_ch1,
    input  logic [W-1:0] fixed_ch2,
    output logic [W-1:0] ch1,
    output logic [W-1:0] ch2
);

    logic [W-1:0] ramp;
    logic [6:0]   lfsr1;
    logic [6:0]   lfsr2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ramp  <= '0;
            lfsr1 <= S1;
            lfsr2 <= S2;
        end else if (reload) begin
            ramp  <= '0;
            lfsr1 <= S1;
            lfsr2 <= S2;
        end else if (advance) begin
            ramp  <= ramp + 1'b1;
            lfsr1 <= prbs7_next(lfsr1);
            lfsr2 <= prbs7_next(lfsr2);
        end
    end

    always_comb begin
        ch1 = IDLE;
        ch2 = IDLE;
        unique case (mode_e'(mode))
            MODE_RAMP: begin
                ch1 = ramp;
                ch2 = ~ramp;
            end
            MODE_PRBS: begin
                ch1 = lfsr1[W-1:0];
                ch2 = lfsr2[W-1:0];
            end
            MODE_FIXED: begin
                ch1 = fixed_ch1;
                ch2 = fixed_ch2;
            end
            default: begin
                ch1 = IDLE;
                ch2 = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/adc_ddr_tx.sv
// ADC emulator: burst FSM, stream handshake and ODDR/OBUFDS output path.
// ch1 goes out in the dco-high half period, ch2 in the low half.
module adc_ddr_tx
    import adc_if_pkg::*;
#(
    parameter int          DW        = adc_if_pkg::DW,
    parameter int          CNT_W     = adc_if_pkg::CNT_W,
    parameter logic [DW-1:0] IDLE_CODE = adc_if_pkg::IDLE_CODE,
    parameter logic [6:0]  SEED1     = adc_if_pkg::SEED1,
    parameter logic [6:0]  SEED2     = adc_if_pkg::SEED2
) (
    input  logic            dco,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic [1:0]      mode,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [DW-1:0]   fixed_ch1,
    input  logic [DW-1:0]   fixed_ch2,
    input  logic [2*DW-1:0] s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic [DW-1:0]   d_p,
    output logic [DW-1:0]   d_n,
    output logic            dco_fwd_p,
    output logic            dco_fwd_n,
    output logic            busy,
    output logic            done,
    output logic [CNT_W-1:0] underrun_cnt,
    output logic [DW-1:0]   dch1_mon,
    output logic [DW-1:0]   dch2_mon
);

    state_e           state;
    mode_e            mode_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    gen_ch1;
    logic [DW-1:0]    gen_ch2;
    logic [DW-1:0]    src_ch1;
    logic [DW-1:0]    src_ch2;
    logic             is_stream;
    logic             last;

    adc_pattern_gen #(
        .W    (DW),
        .IDLE (IDLE_CODE),
        .S1   (SEED1),
        .S2   (SEED2)
    ) u_gen (
        .clk       (dco),
        .rst       (rst),
        .advance   (state == ST_RUN),
        .reload    (state == ST_IDLE && start),
        .mode      (mode_q),
        .fixed_ch1 (fixed_ch1),
        .fixed_ch2 (fixed_ch2),
        .ch1       (gen_ch1),
        .ch2       (gen_ch2)
    );

    assign is_stream = (mode_q == MODE_STREAM);
    assign s_ready   = busy && is_stream;
    assign last      = (len_q != '0) && (cnt == len_q - 1'b1);

    always_comb begin
        src_ch1 = gen_ch1;
        src_ch2 = gen_ch2;
        if (is_stream) begin
            src_ch1 = s_valid ? s_data[DW-1:0]    : IDLE_CODE;
            src_ch2 = s_valid ? s_data[2*DW-1:DW] : IDLE_CODE;
        end
    end

    always_ff @(posedge dco or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            mode_q       <= MODE_STREAM;
            len_q        <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            underrun_cnt <= '0;
            dch1_mon     <= IDLE_CODE;
            dch2_mon     <= IDLE_CODE;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    dch1_mon <= IDLE_CODE;
                    dch2_mon <= IDLE_CODE;
                    if (start) begin
                        state  <= ST_RUN;
                        busy   <= 1'b1;
                        mode_q <= mode_e'(mode);
                        len_q  <= burst_len;
                        cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    dch1_mon <= src_ch1;
                    dch2_mon <= src_ch2;
                    cnt      <= cnt + 1'b1;
                    if (is_stream && !s_valid && !(&underrun_cnt))
                        underrun_cnt <= underrun_cnt + 1'b1;
                    if (stop || last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    dch1_mon <= IDLE_CODE;
                    dch2_mon <= IDLE_CODE;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    // SAME_EDGE ODDR: both halves captured on the rising edge
    logic [DW-1:0] oq1;
    logic [DW-1:0] oq2;
    logic          cq1;
    logic          cq2;
    logic [DW-1:0] d_se;
    logic          c_se;

    always_ff @(posedge dco or posedge rst) begin
        if (rst) begin
            oq1 <= IDLE_CODE;
            oq2 <= IDLE_CODE;
            cq1 <= 1'b0;
            cq2 <= 1'b0;
        end else begin
            oq1 <= dch1_mon;
            oq2 <= dch2_mon;
            cq1 <= 1'b1;
            cq2 <= 1'b0;
        end
    end

    assign d_se = dco ? oq1 : oq2;
    assign c_se = dco ? cq1 : cq2;

    assign d_p       = d_se;
    assign d_n       = ~d_se;
    assign dco_fwd_p = c_se;
    assign dco_fwd_n = ~c_se;

endmodule

// File: tb/tb_adc_ddr_tx.sv
// Directed bench for adc_ddr_tx: ramp, PRBS, stream, pins, controls, reset.
// Outputs are sampled 1 ns after the rising edge of dco.
module tb_adc_ddr_tx;

    logic        dco = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [15:0] burst_len;
    logic [5:0]  fixed_ch1;
    logic [5:0]  fixed_ch2;
    logic [11:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [5:0]  d_p;
    logic [5:0]  d_n;
    logic        dco_fwd_p;
    logic        dco_fwd_n;
    logic        busy;
    logic        done;
    logic [15:0] underrun_cnt;
    logic [5:0]  dch1_mon;
    logic [5:0]  dch2_mon;

    int total = 0;
    int bad   = 0;

    adc_ddr_tx dut (
        .dco          (dco),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .mode         (mode),
        .burst_len    (burst_len),
        .fixed_ch1    (fixed_ch1),
        .fixed_ch2    (fixed_ch2),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .d_p          (d_p),
        .d_n          (d_n),
        .dco_fwd_p    (dco_fwd_p),
        .dco_fwd_n    (dco_fwd_n),
        .busy         (busy),
        .done         (done),
        .underrun_cnt (underrun_cnt),
        .dch1_mon     (dch1_mon),
        .dch2_mon     (dch2_mon)
    );

    always #5 dco = ~dco;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge dco);
        #1;
    endtask

    function automatic logic [6:0] lfsr_nx(input logic [6:0] v);
        return {v[5:0], v[6] ^ v[5]};
    endfunction

    int ramp_c1 [6] = '{0, 0, 1, 2, 3, 0};
    int ramp_c2 [6] = '{0, 63, 62, 61, 60, 0};
    int ramp_bz [6] = '{1, 1, 1, 1, 0, 0};
    int ramp_dn [6] = '{0, 0, 0, 0, 1, 0};

    logic [11:0] st_data [5] = '{12'h041, 12'h082, 12'h000, 12'h0C3, 12'h104};
    logic        st_vld  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int          st_c1   [5] = '{1, 2, 0, 3, 4};
    int          st_c2   [5] = '{1, 2, 0, 3, 4};

    initial begin
        logic [6:0] m1;
        logic [6:0] m2;
        int dn;
        int bz;

        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        mode = 2'd0;
        burst_len = 16'd0;
        fixed_ch1 = 6'h00;
        fixed_ch2 = 6'h00;
        s_data = 12'h000;
        s_valid = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_ch1", dch1_mon, 0);
        chk("rst_pin", d_p, 0);
        rst = 1'b0;
        step();

        // ramp burst of 4
        mode = 2'd1;
        burst_len = 16'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            chk($sformatf("ramp_c1_%0d", i), dch1_mon, ramp_c1[i]);
            chk($sformatf("ramp_c2_%0d", i), dch2_mon, ramp_c2[i]);
            chk($sformatf("ramp_bz_%0d", i), busy, ramp_bz[i]);
            chk($sformatf("ramp_dn_%0d", i), done, ramp_dn[i]);
        end

        // PRBS continuous, stop on the 128th sample
        mode = 2'd2;
        burst_len = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        m1 = 7'h7F;
        m2 = 7'h3C;
        for (int i = 0; i < 128; i++) begin
            if (i == 127) stop = 1'b1;
            step();
            if (i == 0) begin
                chk("prbs_first1", dch1_mon, 6'h3F);
                chk("prbs_first2", dch2_mon, 6'h3C);
            end
            if (i == 1) chk("prbs_second1", dch1_mon, 6'h3E);
            chk($sformatf("prbs_c1_%0d", i), dch1_mon, m1[5:0]);
            chk($sformatf("prbs_c2_%0d", i), dch2_mon, m2[5:0]);
            m1 = lfsr_nx(m1);
            m2 = lfsr_nx(m2);
        end
        stop = 1'b0;
        chk("prbs_period", dch1_mon, 6'h3F);
        chk("prbs_done", done, 1);
        chk("prbs_busy", busy, 0);
        step();
        chk("prbs_done_off", done, 0);

        // stream of 5 with an underrun in slot 3
        mode = 2'd0;
        burst_len = 16'd5;
        chk("st_ready_idle", s_ready, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("st_ready_run", s_ready, 1);
        for (int i = 0; i < 5; i++) begin
            s_data = st_data[i];
            s_valid = st_vld[i];
            step();
            chk($sformatf("st_c1_%0d", i), dch1_mon, st_c1[i]);
            chk($sformatf("st_c2_%0d", i), dch2_mon, st_c2[i]);
        end
        s_valid = 1'b0;
        chk("st_underrun", underrun_cnt, 1);
        chk("st_done", done, 1);
        chk("st_ready_end", s_ready, 0);
        step();

        // fixed pattern observed on the pins
        mode = 2'd3;
        burst_len = 16'd0;
        fixed_ch1 = 6'h2A;
        fixed_ch2 = 6'h15;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("pin_hi_p", d_p, 6'h2A);
        chk("pin_hi_n", d_n, 6'h15);
        chk("clk_hi_p", dco_fwd_p, 1);
        chk("clk_hi_n", dco_fwd_n, 0);
        #5;
        chk("pin_lo_p", d_p, 6'h15);
        chk("pin_lo_n", d_n, 6'h2A);
        chk("clk_lo_p", dco_fwd_p, 0);
        chk("clk_lo_n", dco_fwd_n, 1);
        step();
        chk("pin_hi2_p", d_p, 6'h2A);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("fix_done", done, 1);
        step();

        // start and control changes during RUN are ignored
        mode = 2'd1;
        burst_len = 16'd3;
        start = 1'b1;
        step();
        mode = 2'd2;
        burst_len = 16'd1;
        dn = 0;
        bz = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            start = 1'b0;
            if (i < 3)
                chk($sformatf("ign_c1_%0d", i), dch1_mon, i);
            dn += int'(done);
            bz += int'(busy);
        end
        chk("ign_done_cnt", dn, 1);
        chk("ign_busy_cnt", bz, 3);
        chk("ign_underrun", underrun_cnt, 1);

        // reset in the middle of a 10-sample ramp
        mode = 2'd1;
        burst_len = 16'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("mid_pre_c1", dch1_mon, 2);
        rst = 1'b1;
        #1;
        chk("mid_c1", dch1_mon, 0);
        chk("mid_c2", dch2_mon, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_underrun", underrun_cnt, 0);
        chk("mid_pin", d_p, 0);
        step();
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            dn += int'(done);
        end
        chk("mid_no_done", dn, 0);
        chk("mid_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_ddr_tx.md
Name: adc_ddr_tx

Overview:
- Transmit-side counterpart of the ADC LVDS DDR capture front end. Drives the same 6-pair source-synchronous interface, with a forwarded clock.
- Channel 1 is driven in the rising-edge half-period and channel 2 in the falling-edge half-period. A SAME_EDGE_PIPELINED IDDR receiver therefore recovers ch1 on Q1 and ch2 on Q2.
- Used as an on-board ADC emulator for loopback and bring-up of the capture chain.
- Sample sources: host stream, ramp, PRBS-7 or fixed pattern, sent in bursts.

Parameters:
- DW, 6, bits per channel; also the number of LVDS data pairs.
- CNT_W, 16, width of the burst length and underrun counter.
- IDLE_CODE, 6'h00, value driven on both channels when not running or on underrun.
- SEED1, 7'h7F, PRBS-7 seed for ch1.
- SEED2, 7'h3C, PRBS-7 seed for ch2.

Ports:
- dco  in  1  sample clock; one ch1/ch2 sample pair per cycle.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a burst.
- stop  in  1  one-cycle pulse; ends the current burst.
- mode  in  2  source select: 0 stream, 1 ramp, 2 PRBS-7, 3 fixed.
- burst_len  in  CNT_W  samples per burst; 0 means continuous.
- fixed_ch1  in  DW  ch1 value in fixed mode.
- fixed_ch2  in  DW  ch2 value in fixed mode.
- s_data  in  2*DW  stream sample, {ch2, ch1}.
- s_valid  in  1  stream sample valid.
- s_ready  out  1  stream sample accepted this cycle when s_valid is also high.
- d_p  out  DW  LVDS data, positive leg.
- d_n  out  DW  LVDS data, negative leg.
- dco_fwd_p  out  1  forwarded clock, positive leg.
- dco_fwd_n  out  1  forwarded clock, negative leg.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a burst ends.
- underrun_cnt  out  CNT_W  saturating count of stream underruns.
- dch1_mon  out  DW  registered ch1 value feeding the ODDR (verification tap).
- dch2_mon  out  DW  registered ch2 value feeding the ODDR (verification tap).

Behaviour:
- Clock and reset: single clock dco; reset is asynchronous and active-high.
- Reset values:
  - State IDLE; busy=0, done=0, s_ready=0, underrun_cnt=0.
  - dch1_mon = dch2_mon = IDLE_CODE; pins drive IDLE_CODE.
  - Ramp counter = 0; LFSR1 = SEED1; LFSR2 = SEED2.
  - Reset asserted mid-burst aborts immediately with no done pulse.
- State machine:
  - IDLE:
    - start → RUN.
    - On the start cycle: latch mode and burst_len, clear the sample counter, reload ramp to 0 and both LFSRs to their seeds.
  - RUN:
    - Emits one sample pair per cycle.
    - Exits to DONE when the sample counter reaches latched burst_len−1 (if burst_len≠0), or when stop is asserted.
    - start while in RUN is ignored. Changes to mode or burst_len while in RUN are ignored.
  - DONE:
    - done=1 for exactly one cycle, then → IDLE.
    - start in DONE is ignored.
- Stop behaviour: on the stop cycle, the sample for that cycle is still emitted. If stop and the last count coincide, only one DONE is entered.
- Sources (evaluated in RUN only):
  - Ramp: ch1 = cnt[DW−1:0], ch2 = ~cnt[DW−1:0]; increments every RUN cycle and wraps 63→0.
  - PRBS-7: polynomial x^7+x^6+1, one shift per cycle; channel value = LFSR[DW−1:0].
  - Fixed: fixed_ch1 / fixed_ch2, sampled every cycle.
  - Stream:
    - s_ready = busy && latched mode==0 (combinational).
    - If s_valid is high, emit s_data.
    - Otherwise emit IDLE_CODE on both channels and increment underrun_cnt, saturating at all-ones.
    - The sample slot counts toward burst_len either way.
- Outside RUN, both channels are IDLE_CODE.
- Latency and pinout:
  - The source value is registered into dch1_mon/dch2_mon at edge N.
  - ODDR (SAME_EDGE) drives the pins from edge N+1: ch1 during the high phase, ch2 during the low phase.
  - Forwarded clock is an ODDR with D1=1, D2=0, giving an edge-aligned clock with identical output-path latency.
  - OBUFDS on all 7 pairs.
- underrun_cnt clears only on reset.

Decomposition:
- Package adc_if_pkg holds:
  - DW;
  - mode encodings MODE_STREAM, MODE_RAMP, MODE_PRBS, MODE_FIXED;
  - IDLE_CODE;
  - PRBS taps and seeds;
  - state encoding.
- Sub-module adc_pattern_gen:
  - Contains the ramp counter, both LFSRs, and the fixed/ramp/PRBS mux.
  - Inputs: advance, reload, mode.
- The top level holds the FSM, stream handshake, counters and the ODDR/OBUFDS instances.

Test Plan:
- Ramp burst: mode=1, burst_len=4, start → dch1_mon = 0,1,2,3 and dch2_mon = 63,62,61,60 on the 4 cycles after start; done pulses once on the next cycle; busy high exactly 4 cycles.
- PRBS continuous: mode=2, burst_len=0, start, stop after 127 cycles → ch1 sequence period 127; first value 6'h3F (SEED1 low bits); done one cycle after stop.
- Stream with a gap: mode=0, burst_len=5, s_valid low on the 3rd slot, data 12'h041, 12'h082, –, 12'h0C3, 12'h104 → ch1 = 01,02,00,03,04; underrun_cnt=1; s_ready high only while busy.
- Loopback: adc_ddr_tx pins wired through to the capture front end, fixed 6'h2A / 6'h15 → receiver dch1=6'h2A, dch2=6'h15 steady.
- Reset mid-burst: rst asserted in RUN at sample 3 of 10 → outputs immediately IDLE_CODE, busy=0, no done, underrun_cnt=0.
- Ignored controls: start pulse and mode change during RUN → burst length and source unchanged, exactly one done.
